pooling_stream_engine: RTL and testbench
========================================

// Module: pooling_stream_engine
// PURPOSE
//  Channel-parallel streaming 2-D pooling engine for the cop_engine datapath; successor to the single-channel pooler.
//  Accepts row-major pixels (CHANNELS lanes per beat) and emits one result beat per completed window.
//  Supports window max, window average (KxK, stride K) and global average, plus backpressure on both sides.
//  Sits between the conv/activation output stream and the output SRAM writer.
// PARAMETERS
//  DATA_BITWIDTH     8    unsigned width of one channel sample
//  CHANNELS          4    lanes processed in parallel per beat
//  ADDRESS_BITWIDTH  12   width of the size/count ports
//  MAX_HEIGHT        56   max e_in supported
//  MAX_WIDTH         256  max f_in supported; the row accumulator depth is MAX_WIDTH/2 entries
// PORTS
//  clk           in   1                    clock, rising edge
//  rst           in   1                    asynchronous, active-high reset
//  enable        in   1                    0 = freeze: all state held, write_ready forced 0
//  set_info      in   1                    latch configuration (accepted in IDLE only)
//  kernel_size   in   2                    2 or 3; any other value sets cfg_err
//  pooling_type  in   2                    0 max, 1 global avg, 2 window avg, 3 invalid (cfg_err)
//  e_in          in   ADDRESS_BITWIDTH     input height, latched on set_info
//  f_in          in   ADDRESS_BITWIDTH     input width, latched on set_info
//  data_in       in   CHANNELS*DATA_BITWIDTH  input beat; lane c is bits [c*DW +: DW]
//  write_valid   in   1                    producer has a beat
//  write_ready   out  1                    engine accepts the beat this cycle
//  data_out      out  CHANNELS*DATA_BITWIDTH  result beat, lane layout as data_in
//  read_valid    out  1                    data_out holds a result
//  read_ready    in   1                    consumer takes data_out
//  busy          out  1                    state != IDLE
//  done          out  1                    1-cycle pulse when the last result is consumed
//  cfg_err       out  1                    sticky until the next accepted set_info; config rejected
// BEHAVIOUR
//  Reset: all outputs 0 except write_ready, which is also 0; state IDLE; counters and accumulators cleared.
//  Reset mid-frame aborts the frame; no result is emitted.
//  Handshake: a beat transfers when valid && ready on the same edge.
//  data_out is held stable while read_valid=1 && !read_ready.
//  States:
//   IDLE: on enable && set_info, latch the config; go to STREAM, or raise cfg_err and stay in IDLE.
//     Reject if kernel_size not in {2,3}, pooling_type==3, e_in==0, f_in==0, e_in>MAX_HEIGHT or f_in>MAX_WIDTH.
//     Window modes also reject e_in<K or f_in<K.
//   STREAM: write_ready = enable && !(read_valid && !read_ready).
//     col counts 0..f_in-1, then wraps and row increments.
//     kc/kr track the position inside the window; oc indexes the accumulator.
//     Window modes: acc[oc] is written on kr==0 and max-combined/summed on kr>0. Sum width is DW+4.
//     On the beat where kr==K-1 && kc==K-1, the final value goes to the output register.
//       read_valid rises on the next cycle (latency 1).
//     Avg result = floor(sum/(K*K)): a shift for K=2; a constant divide by 9 for K=3.
//     Edge pixels with col >= (f_in/K)*K or row >= (e_in/K)*K are accepted and discarded (valid padding).
//     The last input beat moves the FSM to DRAIN (window modes) or DIVIDE (global).
//   DIVIDE (global avg): sum width DW+14 per lane; one pool_divider per lane divides by e_in*f_in.
//     Division takes DW+14 cycles; the floor quotient goes to data_out, then read_valid=1 and the FSM enters DRAIN.
//   DRAIN: wait for the last read handshake, pulse done, return to IDLE.
//  Simultaneous capture and read in the same cycle: the read completes and the new result loads; no bubble.
//  set_info outside IDLE is ignored.
//  enable=0 in any state holds everything; read_valid and data_out keep their values.
// STRUCTURE
//  pool_pkg: pool_type_e {POOL_MAX, POOL_GAVG, POOL_WAVG}, state_e {IDLE, STREAM, DIVIDE, DRAIN},
//    MAX_KERNEL_SIZE=3, SUM_EXTRA_BITS=14.
//  Sub-module pool_divider: sequential restoring unsigned divider with a start/busy/done handshake.
//  Per-lane datapath built with a generate loop.
// TESTING
//  1. 4x4 frame, K=2, max, 1 lane, values 0..15 raster -> results 5,7,13,15, in order; done pulses once.
//  2. 6x6 frame, K=3, window avg, all lanes 9 except lane1=200 -> lane outputs 9 / 200; 4 results.
//  3. 5x5 frame, K=2, max -> exactly 4 results; row 4 and column 4 discarded, no hang.
//  4. 2x3 global avg, lane0 = 1,2,3,4,5,6 -> data_out lane0 = 3 after DW+14 (22) cycles.
//  5. read_ready=0 for 10 cycles mid-frame -> write_ready drops, data_out stable; no loss or duplication.
//  6. rst pulse mid-STREAM, then kernel_size=1 config -> cfg_err=1, FSM stays IDLE; valid config then clears cfg_err.

Source files
------------

// File: rtl/pool_pkg.sv
// pool_pkg: shared types and constants for the pooling stream engine
// and its per-lane divider.
package pool_pkg;

  typedef enum logic [1:0] {
    POOL_MAX  = 2'd0,
    POOL_GAVG = 2'd1,
    POOL_WAVG = 2'd2
  } pool_type_e;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DIVIDE,
    DRAIN
  } state_e;

  localparam int MAX_KERNEL_SIZE = 3;
  localparam int SUM_EXTRA_BITS  = 14;
  localparam int KW = $clog2(MAX_KERNEL_SIZE + 1);

  // Position inside a window, wrapping after k-1.
  function automatic logic [KW-1:0] kpos_next(
    input logic [KW-1:0] p,
    input logic [KW-1:0] k
  );
    return (p == k - KW'(1)) ? '0 : p + KW'(1);
  endfunction

endpackage

// File: rtl/pool_divider.sv
// pool_divider: sequential restoring unsigned divider, one quotient
// bit per enabled cycle, start/busy/done handshake.
module pool_divider
  import pool_pkg::*;
#(
  parameter int W  = 22,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  output logic [OW-1:0] quotient,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W:0]    shifted, trial;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[W-1]};
    trial   = shifted - {1'b0, divisor};
    if (start && !busy_q) begin
      rem_d  = '0;
      quo_d  = dividend;
      cnt_d  = CW'(W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Top bit of trial set means the subtraction underflowed.
      if (!trial[W]) begin
        rem_d = trial[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (en) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q[OW-1:0];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: rtl/pooling_stream_engine.sv
// pooling_stream_engine: channel-parallel streaming pooler (window
// max/avg, global avg) with valid/ready on input and output.
module pooling_stream_engine
  import pool_pkg::*;
#(
  parameter int DATA_BITWIDTH    = 8,
  parameter int CHANNELS         = 4,
  parameter int ADDRESS_BITWIDTH = 12,
  parameter int MAX_HEIGHT       = 56,
  parameter int MAX_WIDTH        = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              set_info,
  input  logic [1:0]                        kernel_size,
  input  logic [1:0]                        pooling_type,
  input  logic [ADDRESS_BITWIDTH-1:0]       e_in,
  input  logic [ADDRESS_BITWIDTH-1:0]       f_in,
  input  logic [CHANNELS*DATA_BITWIDTH-1:0] data_in,
  input  logic                              write_valid,
  output logic                              write_ready,
  output logic [CHANNELS*DATA_BITWIDTH-1:0] data_out,
  output logic                              read_valid,
  input  logic                              read_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              cfg_err
);

  localparam int DW    = DATA_BITWIDTH;
  localparam int AW    = ADDRESS_BITWIDTH;
  localparam int BW    = CHANNELS * DW;
  localparam int WSW   = DW + 4;
  localparam int GSW   = DW + SUM_EXTRA_BITS;
  localparam int DEPTH = MAX_WIDTH / 2;
  localparam int OCW   = $clog2(DEPTH);

  state_e          state_q, state_d;
  pool_type_e      ptype_q, ptype_d;
  logic [KW-1:0]   k_q, k_d;
  logic [AW-1:0]   e_q, e_d, f_q, f_d;
  logic [AW-1:0]   clim_q, clim_d, rlim_q, rlim_d;
  logic [AW-1:0]   col_q, col_d, row_q, row_d;
  logic [KW-1:0]   kc_q, kc_d, kr_q, kr_d;
  logic [OCW-1:0]  oc_q, oc_d;
  logic            rv_q, rv_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            dstart_q, dstart_d;
  logic [BW-1:0]   dout_q, dout_d;

  logic            cfg_ok, cfg_accept;
  logic [AW-1:0]   k_ext, clim_in, rlim_in;
  logic            in_fire, out_fire, win_mode;
  logic            in_region, last_beat, win_end;
  logic            first_px, capture, div_done;
  logic [GSW-1:0]  div_den;
  logic [BW-1:0]   win_res, div_res;
  logic [CHANNELS-1:0] div_busy_v, div_done_v;

  always_comb begin
    k_ext  = AW'(kernel_size);
    cfg_ok = (kernel_size == 2'd2 || kernel_size == 2'd3)
          && pooling_type != 2'd3
          && e_in != '0 && f_in != '0
          && e_in <= AW'(MAX_HEIGHT)
          && f_in <= AW'(MAX_WIDTH);
    if (pooling_type != 2'd1 && (e_in < k_ext || f_in < k_ext))
      cfg_ok = 1'b0;
    // Largest multiple of K inside the frame; beyond it is padding.
    if (kernel_size == 2'd3) begin
      clim_in = f_in - f_in % AW'(3);
      rlim_in = e_in - e_in % AW'(3);
    end else begin
      clim_in = {f_in[AW-1:1], 1'b0};
      rlim_in = {e_in[AW-1:1], 1'b0};
    end
    cfg_accept = enable && set_info && state_q == IDLE && cfg_ok;
  end

  always_comb begin
    in_fire   = write_valid && write_ready;
    out_fire  = enable && rv_q && read_ready;
    win_mode  = ptype_q != POOL_GAVG;
    in_region = col_q < clim_q && row_q < rlim_q;
    last_beat = col_q == f_q - AW'(1) && row_q == e_q - AW'(1);
    win_end   = kc_q == k_q - KW'(1) && kr_q == k_q - KW'(1);
    first_px  = kc_q == '0 && kr_q == '0;
    capture   = in_fire && win_mode && in_region && win_end;
    div_done  = (&div_done_v) && !(|div_busy_v);
    div_den   = GSW'(e_q) * GSW'(f_q);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (enable) begin
      unique case (state_q)
        IDLE:    if (cfg_accept) state_d = STREAM;
        STREAM:  if (in_fire && last_beat)
                   state_d = win_mode ? DRAIN : DIVIDE;
        DIVIDE:  if (div_done) state_d = DRAIN;
        DRAIN:   if (!rv_q || read_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy        = state_q != IDLE;
    write_ready = 1'b0;
    if (state_q == STREAM)
      write_ready = enable && !(rv_q && !read_ready);
  end

  always_comb begin
    ptype_d  = ptype_q;
    k_d      = k_q;
    e_d      = e_q;
    f_d      = f_q;
    clim_d   = clim_q;
    rlim_d   = rlim_q;
    col_d    = col_q;
    row_d    = row_q;
    kc_d     = kc_q;
    kr_d     = kr_q;
    oc_d     = oc_q;
    rv_d     = rv_q;
    err_d    = err_q;
    done_d   = 1'b0;
    dstart_d = dstart_q;
    dout_d   = dout_q;
    if (enable) begin
      dstart_d = 1'b0;
      if (state_q == IDLE && set_info) begin
        err_d = !cfg_ok;
        if (cfg_ok) begin
          ptype_d = pool_type_e'(pooling_type);
          k_d     = KW'(kernel_size);
          e_d     = e_in;
          f_d     = f_in;
          clim_d  = clim_in;
          rlim_d  = rlim_in;
          col_d   = '0;
          row_d   = '0;
          kc_d    = '0;
          kr_d    = '0;
          oc_d    = '0;
        end
      end
      if (in_fire) begin
        if (col_q == f_q - AW'(1)) begin
          col_d = '0;
          kc_d  = '0;
          oc_d  = '0;
          row_d = row_q + AW'(1);
          kr_d  = kpos_next(kr_q, k_q);
        end else begin
          col_d = col_q + AW'(1);
          kc_d  = kpos_next(kc_q, k_q);
          if (kc_q == k_q - KW'(1)) oc_d = oc_q + OCW'(1);
        end
        if (last_beat && !win_mode) dstart_d = 1'b1;
      end
      if (out_fire) rv_d = 1'b0;
      if (capture) begin
        rv_d   = 1'b1;
        dout_d = win_res;
      end
      if (state_q == DIVIDE && div_done) begin
        rv_d   = 1'b1;
        dout_d = div_res;
      end
      if (state_q == DRAIN && (!rv_q || read_ready))
        done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptype_q  <= POOL_MAX;
      k_q      <= '0;
      e_q      <= '0;
      f_q      <= '0;
      clim_q   <= '0;
      rlim_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      kc_q     <= '0;
      kr_q     <= '0;
      oc_q     <= '0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      dstart_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      ptype_q  <= ptype_d;
      k_q      <= k_d;
      e_q      <= e_d;
      f_q      <= f_d;
      clim_q   <= clim_d;
      rlim_q   <= rlim_d;
      col_q    <= col_d;
      row_q    <= row_d;
      kc_q     <= kc_d;
      kr_q     <= kr_d;
      oc_q     <= oc_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      done_q   <= done_d;
      dstart_q <= dstart_d;
      dout_q   <= dout_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [DW-1:0]  x;
    logic [WSW-1:0] acc_q [DEPTH];
    logic [WSW-1:0] acc_rd, acc_new;
    logic [DW-1:0]  avg;
    logic [GSW-1:0] gsum_q, gsum_d;
    logic [DW-1:0]  quo;

    assign x      = data_in[c*DW +: DW];
    assign acc_rd = acc_q[oc_q];

    always_comb begin
      acc_new = WSW'(x);
      if (!first_px) begin
        if (ptype_q == POOL_MAX)
          acc_new = (WSW'(x) > acc_rd) ? WSW'(x) : acc_rd;
        else
          acc_new = acc_rd + WSW'(x);
      end
      if (k_q == KW'(3)) avg = DW'(acc_new / WSW'(9));
      else               avg = DW'(acc_new >> 2);
    end

    assign win_res[c*DW +: DW] =
      (ptype_q == POOL_MAX) ? acc_new[DW-1:0] : avg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) acc_q[i] <= '0;
      end else if (in_fire && win_mode && in_region) begin
        acc_q[oc_q] <= acc_new;
      end
    end

    always_comb begin
      gsum_d = gsum_q;
      if (cfg_accept)
        gsum_d = '0;
      else if (in_fire && !win_mode)
        gsum_d = gsum_q + GSW'(x);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) gsum_q <= '0;
      else     gsum_q <= gsum_d;
    end

    pool_divider #(
      .W  (GSW),
      .OW (DW)
    ) u_div (
      .clk      (clk),
      .rst      (rst),
      .en       (enable),
      .start    (dstart_q),
      .dividend (gsum_q),
      .divisor  (div_den),
      .quotient (quo),
      .busy     (div_busy_v[c]),
      .done     (div_done_v[c])
    );

    assign div_res[c*DW +: DW] = quo;
  end

  assign data_out   = dout_q;
  assign read_valid = rv_q;
  assign done       = done_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_pooling_stream_engine.sv
// tb_pooling_stream_engine: random frames against a window/global
// pooling reference model, scoreboard checked by a read monitor.
module tb_pooling_stream_engine;

  localparam int DW = 8;
  localparam int CH = 4;
  localparam int AW = 12;
  localparam int BW = DW * CH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          set_info = 1'b0;
  logic [1:0]    kernel_size = 2'd2;
  logic [1:0]    pooling_type = 2'd0;
  logic [AW-1:0] e_in = '0;
  logic [AW-1:0] f_in = '0;
  logic [BW-1:0] data_in = '0;
  logic          write_valid = 1'b0;
  logic          write_ready;
  logic [BW-1:0] data_out;
  logic          read_valid;
  logic          read_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          cfg_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rr_hold = 0;
  int cyc = 0;
  int rv_cyc = -1;
  int acc_cyc = 0;
  bit track_lat = 1'b0;
  logic [BW-1:0] frame_q[$];
  logic [BW-1:0] exp_q[$];

  pooling_stream_engine dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .set_info     (set_info),
    .kernel_size  (kernel_size),
    .pooling_type (pooling_type),
    .e_in         (e_in),
    .f_in         (f_in),
    .data_in      (data_in),
    .write_valid  (write_valid),
    .write_ready  (write_ready),
    .data_out     (data_out),
    .read_valid   (read_valid),
    .read_ready   (read_ready),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read side: random backpressure plus scoreboard pop/compare.
  initial begin
    logic [BW-1:0] e;
    bit held;
    forever begin
      @(negedge clk);
      held = 1'b0;
      if (rr_hold > 0) begin
        read_ready = 1'b0;
        rr_hold--;
        held = 1'b1;
      end else begin
        read_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      if (!rst) begin
        if (done) done_cnt++;
        if (held && read_valid) begin
          checks++;
          if (write_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_wr: write_ready=%b want 0",
                     write_ready);
          end
        end
        if (track_lat && read_valid && rv_cyc < 0) rv_cyc = cyc;
        if (read_valid && read_ready && enable) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_result: got %h, none expected",
                     data_out);
          end else begin
            e = exp_q.pop_front();
            if (data_out !== e) begin
              errors++;
              $display("FAIL result: got %h want %h", data_out, e);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic model(input int k, input int pt,
                       input int e, input int f);
    logic [BW-1:0] v, b;
    int s, m, p;
    if (pt == 1) begin
      for (int c = 0; c < CH; c++) begin
        s = 0;
        for (int i = 0; i < e * f; i++) begin
          b = frame_q[i];
          s += int'(b[c*DW +: DW]);
        end
        v[c*DW +: DW] = DW'(s / (e * f));
      end
      exp_q.push_back(v);
    end else begin
      for (int wr = 0; wr < e / k; wr++) begin
        for (int wc = 0; wc < f / k; wc++) begin
          for (int c = 0; c < CH; c++) begin
            s = 0;
            m = 0;
            for (int dy = 0; dy < k; dy++) begin
              for (int dx = 0; dx < k; dx++) begin
                b = frame_q[(wr * k + dy) * f + wc * k + dx];
                p = int'(b[c*DW +: DW]);
                s += p;
                if (p > m) m = p;
              end
            end
            v[c*DW +: DW] = DW'((pt == 0) ? m : s / (k * k));
          end
          exp_q.push_back(v);
        end
      end
    end
  endtask

  task automatic cfg(input int k, input int pt, input int e,
                     input int f, input bit want_err);
    @(negedge clk);
    set_info     = 1'b1;
    kernel_size  = 2'(k);
    pooling_type = 2'(pt);
    e_in         = AW'(e);
    f_in         = AW'(f);
    @(negedge clk);
    set_info = 1'b0;
    #1;
    chk("cfg_err", int'(cfg_err), int'(want_err));
    chk("cfg_busy", int'(busy), int'(!want_err));
  endtask

  // Called between a falling and rising edge; returns at one too.
  task automatic send_beat(input logic [BW-1:0] d);
    int t;
    t = 0;
    write_valid = 1'b1;
    data_in     = d;
    forever begin
      #2;
      if (write_ready) break;
      t++;
      if (t > 2000) begin
        checks++;
        errors++;
        $display("FAIL wr_timeout: write_ready=0 want 1");
        break;
      end
      @(negedge clk);
    end
    acc_cyc = cyc;
    @(negedge clk);
    write_valid = 1'b0;
  endtask

  task automatic run_frame(input int k, input int pt, input int e,
                           input int f, input int mode,
                           input bit hold);
    logic [BW-1:0] v;
    int t;
    frame_q.delete();
    for (int i = 0; i < e * f; i++) begin
      v = BW'($urandom);
      case (mode)
        1: v[DW-1:0] = DW'(i);
        2: v = {8'd9, 8'd9, 8'd200, 8'd9};
        3: v[DW-1:0] = DW'(i + 1);
        default: ;
      endcase
      frame_q.push_back(v);
    end
    model(k, pt, e, f);
    done_cnt  = 0;
    rv_cyc    = -1;
    track_lat = (pt == 1);
    cfg(k, pt, e, f, 1'b0);
    for (int i = 0; i < e * f; i++) begin
      if (hold && i == (e * f) / 2) rr_hold = 10;
      send_beat(frame_q[i]);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    if (pt == 1) begin
      for (t = 0; t < 200 && rv_cyc < 0; t++) @(negedge clk);
      checks++;
      if (rv_cyc - acc_cyc - 1 < DW + 14 ||
          rv_cyc - acc_cyc - 1 > DW + 20) begin
        errors++;
        $display("FAIL gavg_latency: got %0d want %0d..%0d",
                 rv_cyc - acc_cyc - 1, DW + 14, DW + 20);
      end
    end
    for (t = 0; t < 3000 && done_cnt == 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("left_in_queue", exp_q.size(), 0);
    chk("idle_after", int'(busy), 0);
    exp_q.delete();
    track_lat = 1'b0;
  endtask

  initial begin
    int k, pt, e, f;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs",
        int'({read_valid, write_ready, busy, done, cfg_err}), 0);
    chk("reset_dout", int'(data_out != '0), 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(2, 0, 4, 4, 1, 1'b0);
    run_frame(3, 2, 6, 6, 2, 1'b0);
    run_frame(2, 0, 5, 5, 0, 1'b0);
    run_frame(2, 1, 2, 3, 3, 1'b0);
    run_frame(2, 2, 8, 8, 0, 1'b1);
    run_frame(3, 0, 3, 256, 0, 1'b1);
    run_frame(2, 2, 2, 256, 0, 1'b0);
    run_frame(3, 1, 7, 9, 0, 1'b1);

    for (int n = 0; n < 6; n++) begin
      k  = $urandom_range(2, 3);
      pt = $urandom_range(0, 2);
      e  = $urandom_range(k, 9);
      f  = $urandom_range(k, 12);
      run_frame(k, pt, e, f, 0, 1'(n % 2));
    end

    // Abort a frame before any window completes.
    cfg(2, 0, 4, 4, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(BW'($urandom));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_rv", int'(read_valid), 0);
    cfg(1, 0, 4, 4, 1'b1);
    cfg(2, 3, 4, 4, 1'b1);
    cfg(3, 2, 2, 8, 1'b1);
    cfg(2, 0, 57, 4, 1'b1);
    cfg(2, 1, 4, 257, 1'b1);
    cfg(2, 2, 0, 4, 1'b1);
    run_frame(2, 0, 4, 6, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
